// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared FSM states and 7-segment tables for the segment serializer.
// SEG_ACTIVE_LOW_EN selects the common-anode blank value.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  localparam int SEG_W = 8;

  // Segment bits {g,f,e,d,c,b,a}; element n is the glyph for BCD digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
`else
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;
`endif

endpackage

// File: rtl/seg_encoder.sv
// rtl/seg_encoder.sv - combinational BCD + decimal point to {dp,g..a} pattern.
// SEG_ACTIVE_LOW_EN inverts the whole pattern for common-anode displays.
module seg_encoder
  import seg_pkg::*;
(
  input  logic [3:0]       bcd,
  input  logic             dp,
  input  logic             valid,
  output logic [SEG_W-1:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    if (valid && (bcd <= 4'd9)) begin
`ifdef SEG_ACTIVE_LOW_EN
      pattern = ~{dp, SEG_TABLE[bcd]};
`else
      pattern = {dp, SEG_TABLE[bcd]};
`endif
    end
  end

endmodule

// File: rtl/seg_serializer.sv
// rtl/seg_serializer.sv - latches one BCD digit per load, shifts its segment pattern out MSB-first.
// Pattern polarity follows SEG_ACTIVE_LOW_EN through seg_encoder.
module seg_serializer #(
  parameter int DIGITS = 6,
  parameter int SEG_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              sl,
  input  logic              a0,
  input  logic              a1,
  input  logic              a2,
  input  logic [DIGITS*4-1:0] digits_bcd,
  input  logic [DIGITS-1:0] dp_mask,
  output logic              ser_data,
  output logic              ser_clk,
  output logic              ser_latch,
  output logic              busy,
  output logic              overrun
);
  import seg_pkg::*;

  state_t           state;
  logic [SEG_W-1:0] shreg;
  logic [2:0]       bit_cnt;
  logic [2:0]       sel;
  logic [3:0]       sel_bcd;
  logic             sel_dp;
  logic             sel_valid;
  logic [7:0]       pattern;

  assign sel = {a2, a1, a0};

  // Out-of-range selects match no digit and leave the encoder blanked.
  always_comb begin
    sel_bcd   = 4'd0;
    sel_dp    = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel == 3'(i)) begin
        sel_bcd   = digits_bcd[4*i +: 4];
        sel_dp    = dp_mask[i];
        sel_valid = 1'b1;
      end
    end
  end

  seg_encoder u_encoder (
    .bcd     (sel_bcd),
    .dp      (sel_dp),
    .valid   (sel_valid),
    .pattern (pattern)
  );

  assign ser_data = shreg[SEG_W-1];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      ser_clk   <= 1'b0;
      ser_latch <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      ser_clk   <= 1'b0;
      ser_latch <= 1'b0;
      if (tick && sl && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (tick && sl) begin
            shreg   <= pattern;
            bit_cnt <= 3'(SEG_W - 1);
            state   <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (tick) begin
            ser_clk <= 1'b1;
            state   <= SHIFT_HI;
          end
        end
        // Data only moves as ser_clk falls, so it is stable across every rise.
        SHIFT_HI: begin
          if (bit_cnt == 3'd0) begin
            state <= LATCH;
          end else begin
            shreg   <= {shreg[SEG_W-2:0], 1'b0};
            bit_cnt <= bit_cnt - 3'd1;
            state   <= SHIFT_LO;
          end
        end
        LATCH: begin
          if (tick) begin
            ser_latch <= 1'b1;
            shreg     <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_serializer.sv
// tb/tb_seg_serializer.sv - table-driven bench for seg_serializer; honours SEG_ACTIVE_LOW_EN.
module tb_seg_serializer;

  localparam int DIGITS = 6;

  typedef struct {
    logic [23:0] bcd;
    logic [5:0]  dp;
    logic [2:0]  sel;
    logic [7:0]  word;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        sl;
  logic        a0, a1, a2;
  logic [23:0] digits_bcd;
  logic [5:0]  dp_mask;
  logic        ser_data, ser_clk, ser_latch, busy, overrun;

  int checks = 0;
  int errors = 0;
  vec_t vecs[12];

  always #5 clk = ~clk;

  seg_serializer #(.DIGITS(DIGITS), .SEG_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .sl         (sl),
    .a0         (a0),
    .a1         (a1),
    .a2         (a2),
    .digits_bcd (digits_bcd),
    .dp_mask    (dp_mask),
    .ser_data   (ser_data),
    .ser_clk    (ser_clk),
    .ser_latch  (ser_latch),
    .busy       (busy),
    .overrun    (overrun)
  );

  function automatic logic [7:0] phys(input logic [7:0] w);
`ifdef SEG_ACTIVE_LOW_EN
    return ~w;
`else
    return w;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // mode 0: tick every 3 cycles; mode 1: 2-cycle ticks (second lands in SHIFT_HI);
  // mode 2: extra load request plus input change mid-frame.
  task automatic run_frame(input vec_t v, input int mode, input string tag);
    logic [7:0] word;
    int nclk, nticks;
    bit latch_seen, stable, busy_ok;
    logic prev_data;
    word = 8'h00; nclk = 0; nticks = 1;
    latch_seen = 0; stable = 1; busy_ok = 1;
    digits_bcd = v.bcd; dp_mask = v.dp; {a2, a1, a0} = v.sel;
    @(negedge clk); tick = 1'b1; sl = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy_load"}, 32'(busy), 32'd1);
    prev_data = ser_data;
    for (int c = 0; c < 200 && !latch_seen; c++) begin
      @(negedge clk);
      tick = (mode == 1) ? ((c % 4) < 2) : ((c % 3) == 2);
      sl = (mode == 2 && c == 2);
      if (mode == 2 && c == 2) begin
        digits_bcd = '0; dp_mask = '0; {a2, a1, a0} = 3'd1;
      end
      if (tick) nticks++;
      @(posedge clk); #1;
      if (ser_clk) begin
        word = {word[6:0], ser_data};
        nclk++;
        if (ser_data !== prev_data) stable = 0;
      end
      if (ser_latch) latch_seen = 1;
      else if (!busy) busy_ok = 0;
      prev_data = ser_data;
    end
    @(negedge clk); tick = 1'b0; sl = 1'b0;
    check({tag, "_latch_seen"}, 32'(latch_seen), 32'd1);
    check({tag, "_word"}, 32'(word), 32'(phys(v.word)));
    check({tag, "_ser_clk_count"}, 32'(nclk), 32'd8);
    check({tag, "_data_stable"}, 32'(stable), 32'd1);
    check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    if (mode == 0) check({tag, "_frame_ticks"}, 32'(nticks), 32'd10);
    @(posedge clk); #1;
    check({tag, "_idle_after"}, 32'({ser_latch, busy, ser_data}), 32'd0);
  endtask

  initial begin
    int n;
    int stray;
    reset = 1'b1; tick = 1'b0; sl = 1'b0;
    {a2, a1, a0} = 3'd0; digits_bcd = '0; dp_mask = '0;

    vecs[0]  = '{24'h123456, 6'h00, 3'd0, 8'h7D};
    vecs[1]  = '{24'h123456, 6'h00, 3'd2, 8'h66};
    vecs[2]  = '{24'h987654, 6'h10, 3'd4, 8'hFF};
    vecs[3]  = '{24'h987654, 6'h08, 3'd3, 8'h87};
    vecs[4]  = '{24'h987654, 6'h3F, 3'd5, 8'hEF};
    vecs[5]  = '{24'h00000A, 6'h3F, 3'd0, 8'h00};
    vecs[6]  = '{24'h987654, 6'h3F, 3'd6, 8'h00};
    vecs[7]  = '{24'h987654, 6'h3F, 3'd7, 8'h00};
    vecs[8]  = '{24'h000010, 6'h00, 3'd1, 8'h06};
    vecs[9]  = '{24'h000230, 6'h00, 3'd1, 8'h4F};
    vecs[10] = '{24'h000230, 6'h04, 3'd2, 8'hDB};
    vecs[11] = '{24'h000000, 6'h00, 3'd0, 8'h3F};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({ser_data, ser_clk, ser_latch, busy, overrun}), 32'd0);
    @(negedge clk); reset = 1'b0;

    // sl without tick must not start a frame
    sl = 1'b1;
    @(posedge clk); #1;
    check("sl_no_tick", 32'(busy), 32'd0);
    @(negedge clk); sl = 1'b0;

    for (int i = 0; i < 12; i++) run_frame(vecs[i], 0, $sformatf("vec%0d", i));
    check("overrun_clear", 32'(overrun), 32'd0);

    run_frame(vecs[2], 1, "hi_tick");

    run_frame(vecs[4], 2, "ovr");
    check("overrun_set", 32'(overrun), 32'd1);
    run_frame(vecs[9], 0, "after_ovr");
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset after the third ser_clk pulse
    digits_bcd = vecs[3].bcd; dp_mask = vecs[3].dp; {a2, a1, a0} = vecs[3].sel;
    @(negedge clk); tick = 1'b1; sl = 1'b1;
    @(negedge clk); tick = 1'b0; sl = 1'b0;
    n = 0;
    for (int c = 0; c < 100 && n < 3; c++) begin
      @(negedge clk); tick = ((c % 3) == 2);
      @(posedge clk); #1;
      if (ser_clk) n++;
    end
    check("rst_mid_reached", 32'(n), 32'd3);
    @(negedge clk); tick = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_outputs", 32'({ser_data, ser_clk, ser_latch, busy, overrun}), 32'd0);
    @(negedge clk); reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); tick = ((c % 3) == 2);
      @(posedge clk); #1;
      if (ser_latch || ser_clk || busy) stray++;
    end
    @(negedge clk); tick = 1'b0;
    check("rst_mid_quiet", 32'(stray), 32'd0);
    run_frame(vecs[0], 0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
